// File: rtl/ex_mult_hilo_unit_if.sv
// EX-stage multiply / HI-LO port bundle: operation issue from the pipeline,
// HI/LO readback and hazard status back to it.
interface ex_mult_hilo_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic             flush;
  logic             hilo_rd;
  logic             busy;
  logic             done;
  logic             stall;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [1:0]       dbg_state;

  modport master (
    output start, op, opA, opB, flush, hilo_rd,
    input  busy, done, stall, hi, lo, dbg_state
  );

  modport slave (
    input  start, op, opA, opB, flush, hilo_rd,
    output busy, done, stall, hi, lo, dbg_state
  );
endinterface

// File: rtl/ex_mult_hilo_unit.sv
// Iterative shift-add multiplier plus HI/LO register file for the EX stage.
// One product bit per cycle; MTHI/MTLO write in a single edge.
module ex_mult_hilo_unit #(
  parameter int WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  ex_mult_hilo_unit_if.slave    bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  // Issue handshake: start is a request that is accepted on any edge where the
  // unit is in IDLE or DONE and flush is low; while busy the request is dropped
  // and stall (busy & (start | hilo_rd)) holds it upstream until busy falls.

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      count_q, count_d;
  logic               neg_q, neg_d;

  logic               can_accept;
  logic               is_mul;
  logic               is_mthi;
  logic               is_mtlo;
  logic               signed_op;
  logic               last_iter;
  logic [WIDTH-1:0]   a_abs;
  logic [WIDTH-1:0]   b_abs;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] product;

  assign can_accept = ((state_q == S_IDLE) || (state_q == S_DONE)) && bus.start && !bus.flush;
  assign is_mul     = can_accept && !bus.op[1];
  assign is_mthi    = can_accept && (bus.op == 2'b10);
  assign is_mtlo    = can_accept && (bus.op == 2'b11);
  assign signed_op  = (bus.op == 2'b00);
  assign last_iter  = (count_q == CW'(WIDTH - 1));

  // Magnitude is taken as an unsigned WIDTH-bit value, so the most negative
  // operand maps to itself and the product still fits in 2*WIDTH bits.
  assign a_abs = (signed_op && bus.opA[WIDTH-1]) ? (~bus.opA + 1'b1) : bus.opA;
  assign b_abs = (signed_op && bus.opB[WIDTH-1]) ? (~bus.opB + 1'b1) : bus.opB;

  assign sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
  assign product = neg_q ? (~acc_q + 1'b1) : acc_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: state_d = is_mul ? S_CALC : S_IDLE;
      S_CALC: begin
        if (bus.flush) begin
          state_d = S_IDLE;
        end else if (last_iter) begin
          state_d = S_FIX;
        end
      end
      S_FIX:  state_d = bus.flush ? S_IDLE : S_DONE;
      S_DONE: state_d = is_mul ? S_CALC : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    bus.busy      = (state_q == S_CALC) || (state_q == S_FIX);
    bus.done      = (state_q == S_DONE);
    bus.stall     = bus.busy && (bus.hilo_rd || bus.start);
    bus.hi        = hi_q;
    bus.lo        = lo_q;
    bus.dbg_state = state_q;
  end

  // Datapath next-state
  always_comb begin
    hi_d     = hi_q;
    lo_d     = lo_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    count_d  = count_q;
    neg_d    = neg_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (is_mul) begin
          mcand_d  = a_abs;
          mplier_d = b_abs;
          neg_d    = signed_op && (bus.opA[WIDTH-1] ^ bus.opB[WIDTH-1]);
          acc_d    = '0;
          count_d  = '0;
        end
        if (is_mthi) begin
          hi_d = bus.opA;
        end
        if (is_mtlo) begin
          lo_d = bus.opA;
        end
      end
      S_CALC: begin
        // Add into the upper half, then shift {carry, acc, multiplier} right.
        if (!bus.flush) begin
          acc_d    = {sum, acc_q[WIDTH-1:1]};
          mplier_d = {acc_q[0], mplier_q[WIDTH-1:1]};
          count_d  = count_q + CW'(1);
        end
      end
      S_FIX: begin
        if (!bus.flush) begin
          {hi_d, lo_d} = product;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q     <= '0;
      lo_q     <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      count_q  <= '0;
      neg_q    <= 1'b0;
    end else begin
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
      neg_q    <= neg_d;
    end
  end

  // A done pulse can never be followed directly by another one.
  a_done_single : assert property (@(posedge clk) disable iff (rst) bus.done |=> !bus.done);
  a_stall_busy  : assert property (@(posedge clk) disable iff (rst) bus.stall |-> bus.busy);

endmodule
